// File: rtl/core_pkg.sv
// Shared core types: branch kinds, AArch64 condition codes
// and NZCV bit positions.
package core_pkg;

  typedef enum logic [1:0] {
    BR_UNCOND = 2'b00,
    BR_COND   = 2'b01,
    BR_CBZ    = 2'b10,
    BR_CBNZ   = 2'b11
  } br_type_t;

  typedef enum logic [3:0] {
    C_EQ = 4'b0000,
    C_NE = 4'b0001,
    C_CS = 4'b0010,
    C_CC = 4'b0011,
    C_MI = 4'b0100,
    C_PL = 4'b0101,
    C_VS = 4'b0110,
    C_VC = 4'b0111,
    C_HI = 4'b1000,
    C_LS = 4'b1001,
    C_GE = 4'b1010,
    C_LT = 4'b1011,
    C_GT = 4'b1100,
    C_LE = 4'b1101,
    C_AL = 4'b1110,
    C_NV = 4'b1111
  } cond_t;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/cond_eval.sv
// AArch64 condition evaluator on {N,Z,C,V}; odd codes invert
// the even base test, except the AL/NV pair which always pass.
module cond_eval
  import core_pkg::*;
(
  input  logic [3:0] flags,
  input  cond_t      cond,
  output logic       pass
);

  logic n, z, c, v;
  logic base;
  logic [2:0] grp;

  assign n = flags[NZCV_N];
  assign z = flags[NZCV_Z];
  assign c = flags[NZCV_C];
  assign v = flags[NZCV_V];
  assign grp = cond[3:1];

  always_comb begin
    base = 1'b0;
    unique case (grp)
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      3'd7: base = 1'b1;
      default: base = 1'b0;
    endcase
  end

  assign pass = (grp == 3'd7) ? 1'b1 : (base ^ cond[0]);

endmodule

// File: rtl/flag_branch_unit.sv
// NZCV register with same-cycle forwarding and one-cycle
// registered branch resolution toward fetch.
module flag_branch_unit
  import core_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_set_flags,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic [3:0]        br_cond,
  input  logic              br_reg_zero,
  input  logic [ADDR_W-1:0] br_target,
  output logic [3:0]        nzcv,
  output logic              resolve_valid,
  output logic              resolve_taken,
  output logic [ADDR_W-1:0] resolve_target,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic       fset;
  logic [3:0] live;
  logic [3:0] eff;
  logic       cpass;
  logic       taken;
  logic       fire;

  assign fset = ex_valid & ex_set_flags;
  assign live = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
  // Forward live flags so B.cond next to ADDS/SUBS needs no stall.
  assign eff  = fset ? live : nzcv;
  assign fire = br_valid & ~flush;

  cond_eval u_cond (
    .flags (eff),
    .cond  (cond_t'(br_cond)),
    .pass  (cpass)
  );

  always_comb begin
    taken = 1'b0;
    unique case (br_type_t'(br_type))
      BR_UNCOND: taken = 1'b1;
      BR_COND:   taken = cpass;
      BR_CBZ:    taken = br_reg_zero;
      BR_CBNZ:   taken = ~br_reg_zero;
      default:   taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nzcv           <= 4'b0000;
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      resolve_target <= '0;
      taken_count    <= '0;
    end else begin
      if (fset & ~flush)
        nzcv <= live;
      resolve_valid <= fire;
      resolve_taken <= fire & taken;
      if (fire & taken) begin
        resolve_target <= br_target;
        taken_count    <= taken_count + CNT_ONE;
      end
    end
  end

endmodule
